// File: rtl/edge_detect_multi.sv
// Multi-channel synchronised, glitch-filtered edge detector with per-channel event enables.
// Define EDGE_STICKY_IRQ_EN for sticky W1C status and a registered aggregate interrupt.
module edge_detect_multi #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int RESET_VAL   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rising_edge_o,
    output logic [WIDTH-1:0] falling_edge_o,
    output logic [WIDTH-1:0] dual_edge_o,
    output logic [WIDTH-1:0] event_o,
    output logic [WIDTH-1:0] status_o,
    output logic             irq_o
);

    localparam int               CNT_W   = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);
    localparam logic [WIDTH-1:0] RST_LVL = (RESET_VAL != 0) ? '1 : '0;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_level;
    logic [CNT_W-1:0] r_cnt  [WIDTH];
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_update;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= RST_LVL;
            end
        end else begin
            r_sync[0] <= a_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // A new level is accepted only after it has differed from the held level for FILT_CYCLES edges.
    always_comb begin
        w_update = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_update[i] = (w_sync[i] != r_level[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= RST_LVL;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_sync[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_update[i]) begin
                    r_level[i] <= w_sync[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            r_rise <= w_update & w_sync;
            r_fall <= w_update & ~w_sync;
        end
    end

    assign level_o        = r_level;
    assign rising_edge_o  = r_rise;
    assign falling_edge_o = r_fall;
    assign dual_edge_o    = r_rise | r_fall;
    assign event_o        = (r_rise & rise_en_i) | (r_fall & fall_en_i);

`ifdef EDGE_STICKY_IRQ_EN
    logic [WIDTH-1:0] r_status;
    logic             r_irq;

    // Set has priority over a simultaneous clear so no event is ever lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_status <= (r_status & ~clr_i) | event_o;
            r_irq    <= |r_status;
        end
    end

    assign status_o = r_status;
    assign irq_o    = r_irq;
`else
    logic w_unused_clr;

    assign w_unused_clr = ^clr_i;
    assign status_o     = '0;
    assign irq_o        = |event_o;
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench for edge_detect_multi: window-based behavioural model plus directed checks.
// Covers both builds; sticky expectations apply when EDGE_STICKY_IRQ_EN is defined.
module tb_edge_detect_multi;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int F  = 4;
    localparam int RV = 0;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] aIn    = '0;
    logic [W-1:0] riseEn = '0;
    logic [W-1:0] fallEn = '0;
    logic [W-1:0] clrIn  = '0;
    logic [W-1:0] levelOut, riseOut, fallOut, dualOut, eventOut, statusOut;
    logic         irqOut;

    logic [W-1:0] aIn2    = '1;
    logic [W-1:0] riseEn2 = '1;
    logic [W-1:0] fallEn2 = '1;
    logic [W-1:0] clrIn2  = '0;
    logic [W-1:0] levelOut2, riseOut2, fallOut2, dualOut2, eventOut2, statusOut2;
    logic         irqOut2;

    int checks   = 0;
    int failures = 0;
    bit cmpEn    = 1'b0;
    int dutEdges  = 0;
    int ch1Rises  = 0;
    int dut2Edges = 0;

    always #5 clk = ~clk;

    edge_detect_multi #(.WIDTH(W), .SYNC_STAGES(S), .FILT_CYCLES(F), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .a_i(aIn), .rise_en_i(riseEn), .fall_en_i(fallEn),
        .clr_i(clrIn), .level_o(levelOut), .rising_edge_o(riseOut), .falling_edge_o(fallOut),
        .dual_edge_o(dualOut), .event_o(eventOut), .status_o(statusOut), .irq_o(irqOut)
    );

    edge_detect_multi #(.WIDTH(W), .SYNC_STAGES(S), .FILT_CYCLES(1), .RESET_VAL(1)) dut2 (
        .clk(clk), .reset(reset), .a_i(aIn2), .rise_en_i(riseEn2), .fall_en_i(fallEn2),
        .clr_i(clrIn2), .level_o(levelOut2), .rising_edge_o(riseOut2), .falling_edge_o(fallOut2),
        .dual_edge_o(dualOut2), .event_o(eventOut2), .status_o(statusOut2), .irq_o(irqOut2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Model: raw samples per edge; a channel flips once the last F synchronised values all disagree with it.
    logic [W-1:0] mRaw [S+F];
    logic [W-1:0] mLevel, mRise, mFall, mStatus;
    logic         mIrq;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < S + F; k++) mRaw[k] = (RV != 0) ? '1 : '0;
            mLevel  = (RV != 0) ? '1 : '0;
            mRise   = '0;
            mFall   = '0;
            mStatus = '0;
            mIrq    = 1'b0;
        end else begin
            logic [W-1:0] ev;
            ev      = (mRise & riseEn) | (mFall & fallEn);
            mIrq    = |mStatus;
            mStatus = (mStatus & ~clrIn) | ev;
            for (int k = S + F - 1; k > 0; k--) mRaw[k] = mRaw[k-1];
            mRaw[0] = aIn;
            mRise   = '0;
            mFall   = '0;
            for (int i = 0; i < W; i++) begin
                bit allDiff;
                allDiff = 1'b1;
                for (int k = S; k < S + F; k++) begin
                    if (mRaw[k][i] == mLevel[i]) allDiff = 1'b0;
                end
                if (allDiff) begin
                    if (mLevel[i]) mFall[i] = 1'b1;
                    else           mRise[i] = 1'b1;
                    mLevel[i] = ~mLevel[i];
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmpEn) begin
            logic [W-1:0] expEvent;
            expEvent = (mRise & riseEn) | (mFall & fallEn);
            checkOutput("m_level", levelOut, mLevel);
            checkOutput("m_rise", riseOut, mRise);
            checkOutput("m_fall", fallOut, mFall);
            checkOutput("m_dual", dualOut, mRise | mFall);
            checkOutput("m_event", eventOut, expEvent);
`ifdef EDGE_STICKY_IRQ_EN
            checkOutput("m_status", statusOut, mStatus);
            checkOutput("m_irq", irqOut, mIrq);
`else
            checkOutput("m_status", statusOut, 0);
            checkOutput("m_irq", irqOut, |expEvent);
`endif
        end
        if (!reset) begin
            if (|dualOut)  dutEdges++;
            if (riseOut[1]) ch1Rises++;
            if (|dualOut2) dut2Edges++;
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] re,
                                 input logic [W-1:0] fe, input logic [W-1:0] clr);
        @(negedge clk);
        aIn    = a;
        riseEn = re;
        fallEn = fe;
        clrIn  = clr;
    endtask

    task automatic driveAndWait(input logic [W-1:0] a, input logic [W-1:0] re,
                                input logic [W-1:0] fe, input logic [W-1:0] clr, input int n);
        applyStimulus(a, re, fe, clr);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmpEn = 1'b1;
        checkOutput("rst_level", levelOut, 0);
        checkOutput("rst_dual", dualOut, 0);
        checkOutput("rst_status", statusOut, 0);
        checkOutput("rst_irq", irqOut, 0);
        checkOutput("rst_level2", levelOut2, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) nextEdge();
        checkOutput("release_edges", dutEdges, 0);
        checkOutput("release_edges2", dut2Edges, 0);

        $display("[TB] test 1: clean rise on channel 0");
        driveAndWait(8'h01, 8'h00, 8'h00, 8'h00, 5);
        checkOutput("t1_e4_rise", riseOut, 8'h00);
        checkOutput("t1_e4_level", levelOut, 8'h00);
        nextEdge();
        checkOutput("t1_e5_rise", riseOut, 8'h01);
        checkOutput("t1_e5_level", levelOut, 8'h01);
        checkOutput("t1_e5_dual", dualOut, 8'h01);
        checkOutput("t1_e5_fall", fallOut, 8'h00);
        nextEdge();
        checkOutput("t1_e6_rise", riseOut, 8'h00);
        checkOutput("t1_e6_dual", dualOut, 8'h00);

        $display("[TB] test 2: glitch rejection on channel 1");
        ch1Rises = 0;
        driveAndWait(8'h03, 8'h00, 8'h00, 8'h00, 3);
        driveAndWait(8'h01, 8'h00, 8'h00, 8'h00, 10);
        checkOutput("t2_glitch_level", levelOut, 8'h01);
        checkOutput("t2_glitch_rises", ch1Rises, 0);
        driveAndWait(8'h03, 8'h00, 8'h00, 8'h00, 4);
        driveAndWait(8'h01, 8'h00, 8'h00, 8'h00, 2);
        checkOutput("t2_pulse_rise", riseOut, 8'h02);
        repeat (4) nextEdge();
        checkOutput("t2_pulse_fall", fallOut, 8'h02);
        checkOutput("t2_pulse_level", levelOut, 8'h01);

        $display("[TB] test 3: per-channel enables");
        driveAndWait(8'h00, 8'h0F, 8'hF0, 8'h00, 10);
        driveAndWait(8'hFF, 8'h0F, 8'hF0, 8'h00, 6);
        checkOutput("t3_rise_all", riseOut, 8'hFF);
        checkOutput("t3_rise_event", eventOut, 8'h0F);
        driveAndWait(8'h00, 8'h0F, 8'hF0, 8'h00, 6);
        checkOutput("t3_fall_all", fallOut, 8'hFF);
        checkOutput("t3_fall_event", eventOut, 8'hF0);
        nextEdge();
        checkOutput("t3_after_event", eventOut, 8'h00);

        $display("[TB] test 4: status and interrupt");
        driveAndWait(8'h04, 8'h04, 8'h04, 8'h00, 6);
        checkOutput("t4_event", eventOut, 8'h04);
`ifdef EDGE_STICKY_IRQ_EN
        checkOutput("t4_irq_e5", irqOut, 0);
        nextEdge();
        checkOutput("t4_status_set", statusOut, 8'h04);
        checkOutput("t4_irq_e6", irqOut, 0);
        nextEdge();
        checkOutput("t4_irq_e7", irqOut, 1);
`else
        checkOutput("t4_irq_pulse", irqOut, 1);
        nextEdge();
        checkOutput("t4_status_zero", statusOut, 8'h00);
        checkOutput("t4_irq_gone", irqOut, 0);
        nextEdge();
`endif
        driveAndWait(8'h00, 8'h04, 8'h04, 8'h00, 6);
        checkOutput("t4_fall_event", eventOut, 8'h04);
        applyStimulus(8'h00, 8'h04, 8'h04, 8'h04);
        nextEdge();
`ifdef EDGE_STICKY_IRQ_EN
        checkOutput("t4_set_wins", statusOut, 8'h04);
`else
        checkOutput("t4_clr_ignored", statusOut, 8'h00);
`endif
        nextEdge();
        checkOutput("t4_cleared", statusOut, 8'h00);
`ifdef EDGE_STICKY_IRQ_EN
        checkOutput("t4_irq_lag", irqOut, 1);
`endif
        applyStimulus(8'h00, 8'h04, 8'h04, 8'h00);
        nextEdge();
        checkOutput("t4_irq_off", irqOut, 0);

        $display("[TB] test 5: reset mid-operation");
        driveAndWait(8'h01, 8'hFF, 8'hFF, 8'h00, 8);
        driveAndWait(8'h09, 8'hFF, 8'hFF, 8'h00, 4);
`ifdef EDGE_STICKY_IRQ_EN
        checkOutput("t5_status_pre", statusOut, 8'h01);
`endif
        #2;
        reset = 1'b1;
        aIn   = 8'h00;
        #1;
        checkOutput("t5_rst_level", levelOut, 0);
        checkOutput("t5_rst_dual", dualOut, 0);
        checkOutput("t5_rst_event", eventOut, 0);
        checkOutput("t5_rst_status", statusOut, 0);
        checkOutput("t5_rst_irq", irqOut, 0);
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        dutEdges  = 0;
        dut2Edges = 0;
        driveAndWait(8'h00, 8'hFF, 8'hFF, 8'h00, 12);
        checkOutput("t5_no_edges", dutEdges, 0);
        checkOutput("t5_level", levelOut, 8'h00);

        $display("[TB] test 6: RESET_VAL=1, FILT_CYCLES=1 instance");
        checkOutput("t6_no_edges", dut2Edges, 0);
        checkOutput("t6_level_hi", levelOut2, 8'hFF);
        @(negedge clk);
        aIn2 = 8'hFE;
        nextEdge();
        nextEdge();
        checkOutput("t6_e1_fall", fallOut2, 8'h00);
        checkOutput("t6_e1_level", levelOut2, 8'hFF);
        nextEdge();
        checkOutput("t6_e2_fall", fallOut2, 8'h01);
        checkOutput("t6_e2_rise", riseOut2, 8'h00);
        checkOutput("t6_e2_dual", dualOut2, 8'h01);
        checkOutput("t6_e2_event", eventOut2, 8'h01);
        checkOutput("t6_e2_level", levelOut2, 8'hFE);
        checkOutput("t6_e2_status", statusOut2, 8'h00);
`ifdef EDGE_STICKY_IRQ_EN
        checkOutput("t6_e2_irq", irqOut2, 0);
`else
        checkOutput("t6_e2_irq", irqOut2, 1);
`endif
        nextEdge();
        checkOutput("t6_e3_fall", fallOut2, 8'h00);

        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
